// File: rtl/cam_frame_buffer.sv
// Ping-pong camera frame buffer: captures one full sensor frame into the write bank,
// then swaps it to the reader (1-cycle random-access read port) unless the reader holds a lock.
module cam_frame_buffer #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int DATA_W     = 8,
    parameter int CONTINUOUS = 1,
    localparam int FRAME_PIX = H_RES * V_RES,
    localparam int ADDR_W    = $clog2(FRAME_PIX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              cam_valid,
    input  logic [DATA_W-1:0] cam_data,
    input  logic              arm,
    input  logic              rd_lock,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_buf,
    output logic              frame_valid,
    output logic              frame_ready,
    output logic              frame_drop,
    output logic              err_short,
    output logic [15:0]       frame_cnt
);

    // One extra address bit selects the bank inside the shared memory.
    localparam int MEM_AW    = ADDR_W + 1;
    localparam int MEM_WORDS = 2 * FRAME_PIX;
    localparam logic [MEM_AW-1:0] BANK_OFS = MEM_AW'(FRAME_PIX);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_PIX - 1);

    typedef enum logic [1:0] {HALT, IDLE, CAPTURE, PENDING} state_t;
    localparam state_t START_STATE = (CONTINUOUS != 0) ? IDLE : HALT;

    logic [DATA_W-1:0] mem [0:MEM_WORDS-1];

    state_t            state_q, state_d;
    logic              vs_q, vs_d;
    logic              wr_buf_q, wr_buf_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              rd_buf_q, rd_buf_d;
    logic              frame_valid_q, frame_valid_d;
    logic              frame_ready_q, frame_ready_d;
    logic              frame_drop_q, frame_drop_d;
    logic              err_short_q, err_short_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              rise;
    logic              pix;
    logic              publish;
    logic              wr_en;
    logic [MEM_AW-1:0] wr_addr;
    logic [MEM_AW-1:0] rd_mem_addr;
    logic              rd_in_range;

    assign rise    = cam_vsync & ~vs_q;
    assign pix     = cam_href & cam_valid;
    assign wr_addr = {1'b0, wr_ptr_q} + (wr_buf_q ? BANK_OFS : MEM_AW'(0));

    always_comb begin
        state_d       = state_q;
        vs_d          = cam_vsync;
        wr_buf_d      = wr_buf_q;
        wr_ptr_d      = wr_ptr_q;
        rd_buf_d      = rd_buf_q;
        frame_valid_d = frame_valid_q;
        frame_ready_d = 1'b0;
        frame_drop_d  = 1'b0;
        err_short_d   = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        publish       = 1'b0;
        wr_en         = 1'b0;

        unique case (state_q)
            HALT: begin
                if (arm) state_d = IDLE;
            end
            IDLE: begin
                if (rise) begin
                    state_d  = CAPTURE;
                    wr_ptr_d = '0;
                end
            end
            CAPTURE: begin
                // A new frame start always wins, even over the completing pixel.
                if (rise) begin
                    err_short_d = 1'b1;
                    wr_ptr_d    = '0;
                end else if (pix) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == LAST_PTR) begin
                        wr_ptr_d = '0;
                        if (!rd_lock) publish = 1'b1;
                        else          state_d = PENDING;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            PENDING: begin
                if (!rd_lock) begin
                    publish = 1'b1;
                end else if (rise) begin
                    frame_drop_d = 1'b1;
                    state_d      = CAPTURE;
                    wr_ptr_d     = '0;
                end
            end
            default: state_d = START_STATE;
        endcase

        if (publish) begin
            rd_buf_d      = wr_buf_q;
            wr_buf_d      = ~wr_buf_q;
            frame_ready_d = 1'b1;
            frame_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + 16'd1;
            state_d       = START_STATE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= START_STATE;
            vs_q          <= 1'b0;
            wr_buf_q      <= 1'b1;
            wr_ptr_q      <= '0;
            rd_buf_q      <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_ready_q <= 1'b0;
            frame_drop_q  <= 1'b0;
            err_short_q   <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            vs_q          <= vs_d;
            wr_buf_q      <= wr_buf_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_buf_q      <= rd_buf_d;
            frame_valid_q <= frame_valid_d;
            frame_ready_q <= frame_ready_d;
            frame_drop_q  <= frame_drop_d;
            err_short_q   <= err_short_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // Memory array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= cam_data;
    end

    assign rd_in_range = ({1'b0, rd_addr} < BANK_OFS);
    assign rd_mem_addr = {1'b0, rd_addr} + (rd_buf_q ? BANK_OFS : MEM_AW'(0));

    always_comb begin
        rd_data_d = '0;
        if (rd_in_range) rd_data_d = mem[rd_mem_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
    end

    assign rd_data     = rd_data_q;
    assign rd_buf      = rd_buf_q;
    assign frame_valid = frame_valid_q;
    assign frame_ready = frame_ready_q;
    assign frame_drop  = frame_drop_q;
    assign err_short   = err_short_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_cam_frame_buffer.sv
// Directed bench for cam_frame_buffer with a 4x2 frame: a continuous-mode instance
// and a single-shot instance share clock and reset.
module tb_cam_frame_buffer;

    localparam int H = 4;
    localparam int V = 2;
    localparam int DW = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          vsync0 = 0, href0 = 0, valid0 = 0, arm0 = 0, lock0 = 0;
    logic [DW-1:0] data0 = '0;
    logic [AW-1:0] addr0 = '0;
    logic [DW-1:0] rdata0;
    logic          rbuf0, fvalid0, fready0, fdrop0, eshort0;
    logic [15:0]   fcnt0;

    logic          vsync1 = 0, href1 = 0, valid1 = 0, arm1 = 0, lock1 = 0;
    logic [DW-1:0] data1 = '0;
    logic [AW-1:0] addr1 = '0;
    logic [DW-1:0] rdata1;
    logic          rbuf1, fvalid1, fready1, fdrop1, eshort1;
    logic [15:0]   fcnt1;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    cam_frame_buffer #(.H_RES(H), .V_RES(V), .DATA_W(DW), .CONTINUOUS(1)) dut0 (
        .clk(clk), .rst(rst),
        .cam_vsync(vsync0), .cam_href(href0), .cam_valid(valid0), .cam_data(data0),
        .arm(arm0), .rd_lock(lock0), .rd_addr(addr0), .rd_data(rdata0),
        .rd_buf(rbuf0), .frame_valid(fvalid0), .frame_ready(fready0),
        .frame_drop(fdrop0), .err_short(eshort0), .frame_cnt(fcnt0)
    );

    cam_frame_buffer #(.H_RES(H), .V_RES(V), .DATA_W(DW), .CONTINUOUS(0)) dut1 (
        .clk(clk), .rst(rst),
        .cam_vsync(vsync1), .cam_href(href1), .cam_valid(valid1), .cam_data(data1),
        .arm(arm1), .rd_lock(lock1), .rd_addr(addr1), .rd_data(rdata1),
        .rd_buf(rbuf1), .frame_valid(fvalid1), .frame_ready(fready1),
        .frame_drop(fdrop1), .err_short(eshort1), .frame_cnt(fcnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cam(input bit sel, input logic vs, input logic hr,
                           input logic vl, input logic [DW-1:0] d);
        if (sel) begin vsync1 = vs; href1 = hr; valid1 = vl; data1 = d; end
        else     begin vsync0 = vs; href0 = hr; valid0 = vl; data0 = d; end
    endtask

    task automatic vs_rise(input bit sel);
        set_cam(sel, 1'b1, 1'b0, 1'b0, '0);
        tick();
        set_cam(sel, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Back-to-back pixels base..base+n-1; inputs idle after the last edge.
    task automatic send_pix(input bit sel, input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            set_cam(sel, 1'b0, 1'b1, 1'b1, base + DW'(i));
            tick();
        end
        set_cam(sel, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic read_bank0(input string tag, input logic [DW-1:0] base);
        for (int a = 0; a < H * V; a++) begin
            addr0 = AW'(a);
            tick();
            chk($sformatf("%s[%0d]", tag, a), 32'(rdata0), 32'(base + DW'(a)));
        end
        addr0 = '0;
    endtask

    initial begin
        // Reset state, sampled while reset is held
        tick();
        tick();
        chk("rst_rd_buf", 32'(rbuf0), 32'd0);
        chk("rst_frame_valid", 32'(fvalid0), 32'd0);
        chk("rst_frame_ready", 32'(fready0), 32'd0);
        chk("rst_frame_drop", 32'(fdrop0), 32'd0);
        chk("rst_err_short", 32'(eshort0), 32'd0);
        chk("rst_frame_cnt", 32'(fcnt0), 32'd0);
        chk("rst_rd_data", 32'(rdata0), 32'd0);
        rst = 1'b0;
        tick();

        // Frame 1: bank 1, 0x10..0x17
        vs_rise(0);
        send_pix(0, 8'h10, 8);
        chk("f1_ready", 32'(fready0), 32'd1);
        chk("f1_rd_buf", 32'(rbuf0), 32'd1);
        chk("f1_cnt", 32'(fcnt0), 32'd1);
        chk("f1_valid", 32'(fvalid0), 32'd1);
        tick();
        chk("f1_ready_pulse", 32'(fready0), 32'd0);
        read_bank0("f1_rd", 8'h10);

        // Short frame after 5 pixels, then full frame 0x20..0x27 into bank 0
        vs_rise(0);
        send_pix(0, 8'h30, 5);
        vs_rise(0);
        chk("short_err", 32'(eshort0), 32'd1);
        chk("short_rd_buf", 32'(rbuf0), 32'd1);
        chk("short_cnt", 32'(fcnt0), 32'd1);
        chk("short_ready", 32'(fready0), 32'd0);
        send_pix(0, 8'h20, 8);
        chk("f2_ready", 32'(fready0), 32'd1);
        chk("f2_rd_buf", 32'(rbuf0), 32'd0);
        chk("f2_cnt", 32'(fcnt0), 32'd2);
        chk("f2_err_clear", 32'(eshort0), 32'd0);
        read_bank0("f2_rd", 8'h20);

        // Locked reader: frame 3 (0x40..) pends until the lock drops
        lock0 = 1'b1;
        vs_rise(0);
        send_pix(0, 8'h40, 8);
        chk("lock_no_ready", 32'(fready0), 32'd0);
        chk("lock_rd_buf", 32'(rbuf0), 32'd0);
        tick();
        tick();
        chk("lock_rd_buf_hold", 32'(rbuf0), 32'd0);
        chk("lock_cnt_hold", 32'(fcnt0), 32'd2);
        addr0 = 3'd5;
        tick();
        chk("lock_old_data", 32'(rdata0), 32'h25);
        lock0 = 1'b0;
        tick();
        chk("unlock_ready", 32'(fready0), 32'd1);
        chk("unlock_rd_buf", 32'(rbuf0), 32'd1);
        chk("unlock_cnt", 32'(fcnt0), 32'd3);
        read_bank0("f3_rd", 8'h40);

        // Pending frame dropped by a new vsync; replacement reaches the reader
        lock0 = 1'b1;
        vs_rise(0);
        send_pix(0, 8'h50, 8);
        chk("drop_pend_ready", 32'(fready0), 32'd0);
        vs_rise(0);
        chk("drop_pulse", 32'(fdrop0), 32'd1);
        chk("drop_no_err", 32'(eshort0), 32'd0);
        send_pix(0, 8'h60, 8);
        chk("drop_pulse_clear", 32'(fdrop0), 32'd0);
        chk("drop_no_ready", 32'(fready0), 32'd0);
        chk("drop_rd_buf", 32'(rbuf0), 32'd1);
        lock0 = 1'b0;
        tick();
        chk("drop_pub_ready", 32'(fready0), 32'd1);
        chk("drop_pub_rd_buf", 32'(rbuf0), 32'd0);
        chk("drop_pub_cnt", 32'(fcnt0), 32'd4);
        read_bank0("f4_rd", 8'h60);

        // vsync together with the last pixel counts as a short frame
        vs_rise(0);
        send_pix(0, 8'h70, 7);
        set_cam(0, 1'b1, 1'b1, 1'b1, 8'h77);
        tick();
        set_cam(0, 1'b0, 1'b0, 1'b0, '0);
        chk("tie_err", 32'(eshort0), 32'd1);
        chk("tie_ready", 32'(fready0), 32'd0);
        chk("tie_cnt", 32'(fcnt0), 32'd4);
        send_pix(0, 8'h80, 8);
        chk("tie_next_ready", 32'(fready0), 32'd1);
        chk("tie_next_rd_buf", 32'(rbuf0), 32'd1);
        chk("tie_next_cnt", 32'(fcnt0), 32'd5);
        read_bank0("f5_rd", 8'h80);

        // Asynchronous reset in the middle of a capture
        vs_rise(0);
        send_pix(0, 8'h90, 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_buf", 32'(rbuf0), 32'd0);
        chk("mid_rst_cnt", 32'(fcnt0), 32'd0);
        chk("mid_rst_valid", 32'(fvalid0), 32'd0);
        chk("mid_rst_ready", 32'(fready0), 32'd0);
        chk("mid_rst_rd_data", 32'(rdata0), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        vs_rise(0);
        send_pix(0, 8'hA0, 8);
        chk("post_rst_ready", 32'(fready0), 32'd1);
        chk("post_rst_rd_buf", 32'(rbuf0), 32'd1);
        chk("post_rst_cnt", 32'(fcnt0), 32'd1);
        read_bank0("f6_rd", 8'hA0);

        // Single-shot instance: nothing happens until armed, one frame per arm
        vs_rise(1);
        send_pix(1, 8'hD0, 8);
        tick();
        chk("ss_noarm_cnt", 32'(fcnt1), 32'd0);
        chk("ss_noarm_valid", 32'(fvalid1), 32'd0);
        chk("ss_noarm_rd_buf", 32'(rbuf1), 32'd0);
        arm1 = 1'b1;
        tick();
        arm1 = 1'b0;
        vs_rise(1);
        send_pix(1, 8'hB0, 8);
        chk("ss_arm_ready", 32'(fready1), 32'd1);
        chk("ss_arm_cnt", 32'(fcnt1), 32'd1);
        chk("ss_arm_rd_buf", 32'(rbuf1), 32'd1);
        addr1 = 3'd3;
        tick();
        chk("ss_arm_rd", 32'(rdata1), 32'hB3);
        vs_rise(1);
        send_pix(1, 8'hC0, 8);
        tick();
        chk("ss_rearm_cnt", 32'(fcnt1), 32'd1);
        chk("ss_rearm_rd_buf", 32'(rbuf1), 32'd1);
        chk("ss_rearm_ready", 32'(fready1), 32'd0);
        chk("ss_rearm_rd", 32'(rdata1), 32'hB3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
